store_commit_ctrl: RTL and testbench

STORE_COMMIT_CTRL -- requirements
Module: store_commit_ctrl

---
 rtl/store_commit_ctrl.sv | 126 ++++++++++++
 tb/tb_store_commit_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/store_commit_ctrl.sv
// Store commit controller: counts retired stores, pops the store buffer head one at a time,
// issues each as a data-cache write, and holds flush requests until every retired store drains.
module store_commit_ctrl #(
  parameter int unsigned STORE_GROUP = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           retire_store,
  input  logic                           flush_req,
  output logic                           flush_out,
  output logic                           flush_busy,
  output logic                           commit_store_valid,
  input  logic [3:0]                     commit_store_wstrb,
  input  logic [2:0]                     commit_store_size,
  input  logic [31:0]                    commit_store_addr,
  input  logic [31:0]                    commit_store_data,
  output logic                           dc_req,
  output logic                           dc_wr,
  output logic [3:0]                     dc_wstrb,
  output logic [2:0]                     dc_size,
  output logic [31:0]                    dc_addr,
  output logic [31:0]                    dc_wdata,
  input  logic                           dc_addr_ok,
  input  logic                           dc_data_ok,
  output logic [$clog2(STORE_GROUP):0]   pend_cnt,
  output logic                           ovf_err
);

  localparam int unsigned CntW = $clog2(STORE_GROUP) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(STORE_GROUP);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e          state_q;
  logic [CntW-1:0] pend_q, pend_d;
  logic            ovf_q, ovf_d;
  logic            flush_pend_q, flush_pend_d;
  logic [3:0]      wstrb_q;
  logic [2:0]      size_q;
  logic [31:0]     addr_q;
  logic [31:0]     data_q;

  logic in_idle, pop, drained, flush_fire;

  always_comb begin
    in_idle    = (state_q == StIdle);
    pop        = in_idle && (pend_q != '0);
    drained    = in_idle && (pend_q == '0) && !retire_store;
    flush_fire = (flush_req | flush_pend_q) & drained;

    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (retire_store && !pop) begin
      // A retire into a full group has nowhere to go: hold the count, flag the error.
      if (pend_q == CntFull) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (pop && !retire_store) begin
      pend_d = pend_q - 1'b1;
    end

    flush_pend_d = flush_pend_q;
    if (flush_fire) begin
      flush_pend_d = 1'b0;
    end else if (flush_req && !drained) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pend_q       <= '0;
      ovf_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      wstrb_q      <= '0;
      size_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      pend_q       <= pend_d;
      ovf_q        <= ovf_d;
      flush_pend_q <= flush_pend_d;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            wstrb_q <= commit_store_wstrb;
            size_q  <= commit_store_size;
            addr_q  <= commit_store_addr;
            data_q  <= commit_store_data;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (dc_addr_ok) begin
            state_q <= dc_data_ok ? StIdle : StWait;
          end
        end
        StWait: begin
          if (dc_data_ok) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs are forced low for the whole reset cycle, not just after it.
  always_comb begin
    commit_store_valid = !reset && pop;
    flush_out          = !reset && flush_fire;
    flush_busy         = !reset && flush_pend_q;
    dc_req             = !reset && (state_q == StReq);
    dc_wr              = dc_req;
    dc_wstrb           = reset ? '0 : wstrb_q;
    dc_size            = reset ? '0 : size_q;
    dc_addr            = reset ? '0 : addr_q;
    dc_wdata           = reset ? '0 : data_q;
    pend_cnt           = reset ? '0 : pend_q;
    ovf_err            = !reset && ovf_q;
  end

endmodule

// File: tb/tb_store_commit_ctrl.sv
// Bench for store_commit_ctrl: directed scenarios then random traffic, checked against a
// transaction-level model and a scoreboard of expected data-cache writes.
module tb_store_commit_ctrl;
  localparam int unsigned SG = 16;
  localparam int unsigned CW = $clog2(SG) + 1;

  logic          clk = 1'b0;
  logic          reset, retire_store, flush_req;
  logic          flush_out, flush_busy, commit_store_valid;
  logic [3:0]    commit_store_wstrb;
  logic [2:0]    commit_store_size;
  logic [31:0]   commit_store_addr, commit_store_data;
  logic          dc_req, dc_wr;
  logic [3:0]    dc_wstrb;
  logic [2:0]    dc_size;
  logic [31:0]   dc_addr, dc_wdata;
  logic          dc_addr_ok, dc_data_ok;
  logic [CW-1:0] pend_cnt;
  logic          ovf_err;

  always #5 clk = ~clk;

  store_commit_ctrl #(.STORE_GROUP(SG)) dut (
    .clk(clk), .reset(reset), .retire_store(retire_store), .flush_req(flush_req),
    .flush_out(flush_out), .flush_busy(flush_busy), .commit_store_valid(commit_store_valid),
    .commit_store_wstrb(commit_store_wstrb), .commit_store_size(commit_store_size),
    .commit_store_addr(commit_store_addr), .commit_store_data(commit_store_data),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_wstrb(dc_wstrb), .dc_size(dc_size),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_addr_ok(dc_addr_ok), .dc_data_ok(dc_data_ok),
    .pend_cnt(pend_cnt), .ovf_err(ovf_err)
  );

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } store_t;

  store_t sbuf[$];   // retired stores still in the store buffer
  store_t exp_q[$];  // popped stores, in the order the cache must see them

  int checks = 0;
  int failures = 0;

  // Model: number of retired, unpopped stores; whether a write is awaiting acceptance
  // or completion; flush held; sticky error.
  int m_cnt;
  bit m_need_addr, m_need_data, m_flush_held, m_ovf;

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  task automatic step(input bit rst, input bit ret, input bit fr, input bit aok, input bit dok);
    bit     idle, e_csv, e_drained, e_fo;
    store_t hd;
    reset        = rst;
    retire_store = ret;
    flush_req    = fr;
    dc_addr_ok   = aok;
    dc_data_ok   = dok;
    if (sbuf.size() > 0) hd = sbuf[0];
    else hd = {$urandom(), $urandom(), $urandom()};
    commit_store_wstrb = hd.wstrb;
    commit_store_size  = hd.size;
    commit_store_addr  = hd.addr;
    commit_store_data  = hd.data;
    @(negedge clk);
    idle      = !m_need_addr && !m_need_data;
    e_csv     = !rst && idle && m_cnt > 0;
    e_drained = idle && m_cnt == 0 && !ret;
    e_fo      = !rst && (fr || m_flush_held) && e_drained;
    chk("commit_store_valid", commit_store_valid, e_csv);
    chk("flush_out", flush_out, e_fo);
    chk("flush_busy", flush_busy, !rst && m_flush_held);
    chk("dc_req", dc_req, !rst && m_need_addr);
    chk("dc_wr", dc_wr, !rst && m_need_addr);
    chk("pend_cnt", pend_cnt, rst ? 0 : m_cnt);
    chk("ovf_err", ovf_err, !rst && m_ovf);
    if (rst) begin
      chk("dc_addr_in_reset", dc_addr, 0);
      m_cnt = 0; m_need_addr = 0; m_need_data = 0; m_flush_held = 0; m_ovf = 0;
      sbuf.delete();
      exp_q.delete();
    end else begin
      if (m_need_data) begin
        if (dok) m_need_data = 0;
      end else if (m_need_addr) begin
        if (aok) begin
          m_need_addr = 0;
          m_need_data = !dok;
        end
      end
      if (e_csv) begin
        exp_q.push_back(sbuf.pop_front());
        m_need_addr = 1;
      end
      if (ret) begin
        if (!e_csv && m_cnt == SG) m_ovf = 1;
        else sbuf.push_back({4'($urandom()), 3'($urandom()), 32'($urandom()), 32'($urandom())});
      end
      m_cnt = m_cnt + ((ret && !(m_cnt == SG && !e_csv)) ? 1 : 0) - (e_csv ? 1 : 0);
      if (e_fo) m_flush_held = 0;
      else if (fr && !e_drained) m_flush_held = 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted cache request must match the next popped store.
  initial begin
    store_t e;
    forever begin
      @(negedge clk);
      if (dc_req === 1'b1 && dc_addr_ok === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dc_unexpected_write at %0t: got addr %0h expected no write",
                   $time, dc_addr);
        end else begin
          e = exp_q.pop_front();
          chk("dc_wstrb", dc_wstrb, e.wstrb);
          chk("dc_size", dc_size, e.size);
          chk("dc_addr", dc_addr, e.addr);
          chk("dc_wdata", dc_wdata, e.data);
        end
      end
    end
  end

  initial begin
    reset = 1; retire_store = 0; flush_req = 0; dc_addr_ok = 0; dc_data_ok = 0;
    commit_store_wstrb = '0; commit_store_size = '0;
    commit_store_addr = '0; commit_store_data = '0;
    m_cnt = 0; m_need_addr = 0; m_need_data = 0; m_flush_held = 0; m_ovf = 0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);

    // Idle flush goes straight through.
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);

    // Single store: accept on cycle 4, complete on cycle 6.
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Three back-to-back stores with same-cycle accept and complete.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);

    // Flush arriving with two stores still pending.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1);

    // Overflow: the cache never accepts while stores keep retiring.
    for (int i = 0; i < 18; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 1, 1);

    // Reset while a write waits for completion.
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(999) < 2, $urandom_range(99) < 35, $urandom_range(99) < 4,
           $urandom_range(99) < 50, $urandom_range(99) < 50);
    end

    for (int i = 0; i < 60; i++) step(0, 0, 0, 1, 1);
    chk("final_pend_cnt", pend_cnt, 0);
    chk("final_writes_outstanding", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
